dircc_avalon_st_packet_source: RTL and testbench

Avalon-ST packet source: the transmit end of the streaming interface that terminal sinks consume. It emits programmable, deterministic packets (start/end of packet, empty, ready/valid backpressure) and is configured and polled over a small 16-bit Avalon-MM slave. It serves as a traffic generator in the GALS simulation system, driving sinks and routers under test.

---
 rtl/dircc_avalon_st_packet_source.sv | 215 +++++++++++++++++++++
 tb/tb_dircc_avalon_st_packet_source.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/dircc_avalon_st_packet_source.sv
// Avalon-ST packet source with a 16-bit Avalon-MM control slave.
// It emits deterministic packets. Beat k carries {BASE, k} in the low 32 bits.
// Ports:
//   clk, reset            - clock and synchronous active-high reset
//   data/empty/sop/eop/valid, ready - Avalon-ST source (ready latency 0)
//   address/writedata/write_n/read_n/readdata - control slave, 1-cycle reads
module dircc_avalon_st_packet_source #(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic [DATA_WIDTH-1:0] data,
  output logic [1:0]            empty,
  output logic                  endofpacket,
  output logic                  startofpacket,
  output logic                  valid,
  input  logic                  ready,
  input  logic [1:0]            address,
  input  logic [15:0]           writedata,
  input  logic                  write_n,
  input  logic                  read_n,
  output logic [15:0]           readdata
);

  localparam int unsigned CNT_W = 8;

  typedef enum logic {ST_IDLE, ST_SEND} state_t;

  state_t state_q, state_d;

  // programmed configuration and working copies latched on start
  logic [CNT_W-1:0] length_q, length_d;
  logic [15:0]      base_q, base_d;
  logic [1:0]       shape_empty_q, shape_empty_d;
  logic [CNT_W-1:0] shape_pkts_q, shape_pkts_d;
  logic [CNT_W-1:0] w_len_q, w_len_d;
  logic [15:0]      w_base_q, w_base_d;
  logic [1:0]       w_empty_q, w_empty_d;
  logic [CNT_W-1:0] w_pkts_q, w_pkts_d;

  logic [CNT_W-1:0] beat_q, beat_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             done_q, done_d;
  logic             stop_q, stop_d;

  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic [1:0]            empty_q, empty_d;
  logic                  sop_q, sop_d;
  logic                  eop_q, eop_d;
  logic                  valid_q, valid_d;
  logic [15:0]           readdata_q, readdata_d;

  logic             wr, rd, start_wr, stop_wr, busy, xfer, last_beat;
  logic [CNT_W-1:0] pkt_next;

  assign wr        = !write_n;
  assign rd        = !read_n;
  assign start_wr  = wr && (address == 2'd0) && writedata[0];
  assign stop_wr   = wr && (address == 2'd0) && writedata[1];
  assign busy      = (state_q == ST_SEND);
  assign xfer      = valid_q && ready;
  assign last_beat = (beat_q == CNT_W'(w_len_q - CNT_W'(1)));
  assign pkt_next  = CNT_W'(pkt_q + CNT_W'(1));

  // state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // next-state, register file and packet sequencing
  always_comb begin
    state_d       = state_q;
    length_d      = length_q;
    base_d        = base_q;
    shape_empty_d = shape_empty_q;
    shape_pkts_d  = shape_pkts_q;
    w_len_d       = w_len_q;
    w_base_d      = w_base_q;
    w_empty_d     = w_empty_q;
    w_pkts_d      = w_pkts_q;
    beat_d        = beat_q;
    pkt_d         = pkt_q;
    cnt_d         = cnt_q;
    done_d        = done_q;
    stop_d        = stop_q;
    readdata_d    = readdata_q;

    // readdata captures pre-write state; a status read clears done
    if (rd) begin
      case (address)
        2'd0: begin
          readdata_d = {busy, done_q, 6'b0, cnt_q};
          done_d     = 1'b0;
        end
        2'd1:    readdata_d = {8'h00, length_q};
        2'd2:    readdata_d = base_q;
        default: readdata_d = {shape_pkts_q, 6'b0, shape_empty_q};
      endcase
    end

    case (state_q)
      ST_IDLE: begin
        if (wr) begin
          case (address)
            2'd1: length_d = writedata[7:0];
            2'd2: base_d   = writedata;
            2'd3: begin
              shape_empty_d = writedata[1:0];
              shape_pkts_d  = writedata[15:8];
            end
            default: ;
          endcase
        end
        if (start_wr) begin
          state_d   = ST_SEND;
          w_len_d   = (length_q == '0) ? CNT_W'(1) : length_q;
          w_base_d  = base_q;
          w_empty_d = shape_empty_q;
          w_pkts_d  = (shape_pkts_q == '0) ? CNT_W'(1) : shape_pkts_q;
          done_d    = 1'b0;
          beat_d    = '0;
          pkt_d     = '0;
          stop_d    = 1'b0;
        end
      end
      default: begin
        if (stop_wr) stop_d = 1'b1;
        if (xfer) begin
          if (last_beat) begin
            cnt_d = CNT_W'(cnt_q + CNT_W'(1));
            pkt_d = pkt_next;
            // a stop written in this very cycle also ends the burst
            if ((pkt_next < w_pkts_q) && !(stop_q || stop_wr)) begin
              beat_d = '0;
            end else begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
              stop_d  = 1'b0;
            end
          end else begin
            beat_d = CNT_W'(beat_q + CNT_W'(1));
          end
        end
      end
    endcase
  end

  // stream outputs derived from the next beat so they are registered
  always_comb begin
    valid_d = (state_d == ST_SEND);
    sop_d   = valid_d && (beat_d == '0);
    eop_d   = valid_d && (beat_d == CNT_W'(w_len_d - CNT_W'(1)));
    empty_d = eop_d ? w_empty_d : 2'b00;
    data_d  = '0;
    if (valid_d) begin
      data_d[31:16] = w_base_d;
      data_d[15:0]  = 16'(beat_d);
    end
  end

  // datapath and output registers
  always_ff @(posedge clk) begin
    if (reset) begin
      length_q      <= CNT_W'(1);
      base_q        <= '0;
      shape_empty_q <= '0;
      shape_pkts_q  <= '0;
      w_len_q       <= CNT_W'(1);
      w_base_q      <= '0;
      w_empty_q     <= '0;
      w_pkts_q      <= CNT_W'(1);
      beat_q        <= '0;
      pkt_q         <= '0;
      cnt_q         <= '0;
      done_q        <= 1'b0;
      stop_q        <= 1'b0;
      data_q        <= '0;
      empty_q       <= '0;
      sop_q         <= 1'b0;
      eop_q         <= 1'b0;
      valid_q       <= 1'b0;
      readdata_q    <= '0;
    end else begin
      length_q      <= length_d;
      base_q        <= base_d;
      shape_empty_q <= shape_empty_d;
      shape_pkts_q  <= shape_pkts_d;
      w_len_q       <= w_len_d;
      w_base_q      <= w_base_d;
      w_empty_q     <= w_empty_d;
      w_pkts_q      <= w_pkts_d;
      beat_q        <= beat_d;
      pkt_q         <= pkt_d;
      cnt_q         <= cnt_d;
      done_q        <= done_d;
      stop_q        <= stop_d;
      data_q        <= data_d;
      empty_q       <= empty_d;
      sop_q         <= sop_d;
      eop_q         <= eop_d;
      valid_q       <= valid_d;
      readdata_q    <= readdata_d;
    end
  end

  assign data          = data_q;
  assign empty         = empty_q;
  assign startofpacket = sop_q;
  assign endofpacket   = eop_q;
  assign valid         = valid_q;
  assign readdata      = readdata_q;

endmodule

// File: tb/tb_dircc_avalon_st_packet_source.sv
// Directed bench for dircc_avalon_st_packet_source.
module tb_dircc_avalon_st_packet_source;

  localparam int unsigned DW = 32;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic [DW-1:0] data;
  logic [1:0]    empty;
  logic          endofpacket, startofpacket, valid;
  logic          ready = 1'b1;
  logic [1:0]    address = 2'd0;
  logic [15:0]   writedata = 16'h0;
  logic          write_n = 1'b1;
  logic          read_n = 1'b1;
  logic [15:0]   readdata;

  int n_chk = 0;
  int n_fail = 0;

  dircc_avalon_st_packet_source #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset), .data(data), .empty(empty),
    .endofpacket(endofpacket), .startofpacket(startofpacket), .valid(valid),
    .ready(ready), .address(address), .writedata(writedata),
    .write_n(write_n), .read_n(read_n), .readdata(readdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; step(); step(); reset = 1'b0;
  endtask

  task automatic mm_write(input logic [1:0] a, input logic [15:0] d);
    address = a; writedata = d; write_n = 1'b0;
    step();
    write_n = 1'b1;
  endtask

  task automatic mm_read(input logic [1:0] a, output logic [15:0] v);
    address = a; read_n = 1'b0;
    step();
    read_n = 1'b1;
    v = readdata;
  endtask

  task automatic chk_beat(input string tag, input int k, input int len,
                          input logic [15:0] base, input logic [1:0] emp);
    logic [31:0] exp_data;
    exp_data = {base, 16'(k)};
    chk({tag, ".valid"}, 64'(valid), 64'd1);
    chk({tag, ".data"},  64'(data), 64'(exp_data));
    chk({tag, ".sop"},   64'(startofpacket), 64'(k == 0));
    chk({tag, ".eop"},   64'(endofpacket), 64'(k == len - 1));
    chk({tag, ".empty"}, 64'(empty), (k == len - 1) ? 64'(emp) : 64'd0);
  endtask

  initial begin
    logic [15:0] rv;
    int k, nvalid, nxfer;

    // reset state
    do_reset();
    chk("rst.valid", 64'(valid), 64'd0);
    chk("rst.data", 64'(data), 64'd0);
    chk("rst.readdata", 64'(readdata), 64'd0);
    mm_read(2'd0, rv); chk("rst.ctrl", 64'(rv), 64'h0000);
    mm_read(2'd1, rv); chk("rst.length", 64'(rv), 64'h0001);
    chk("rst.valid2", 64'(valid), 64'd0);

    // two 4-beat packets, ready held high
    mm_write(2'd1, 16'd4);
    mm_write(2'd2, 16'hABCD);
    mm_write(2'd3, 16'h0202);
    ready = 1'b1;
    mm_write(2'd0, 16'h0001);
    for (int i = 0; i < 8; i++) begin
      chk_beat($sformatf("b2b%0d", i), i % 4, 4, 16'hABCD, 2'd2);
      step();
    end
    chk("b2b.idle", 64'(valid), 64'd0);
    mm_read(2'd0, rv); chk("b2b.status", 64'(rv), 64'h4002);

    // same packets with ready toggling
    do_reset();
    mm_write(2'd1, 16'd4);
    mm_write(2'd2, 16'hABCD);
    mm_write(2'd3, 16'h0202);
    ready = 1'b1;
    mm_write(2'd0, 16'h0001);
    k = 0; nvalid = 0; nxfer = 0;
    for (int c = 0; c < 40 && nxfer < 8; c++) begin
      ready = ~ready;
      if (valid) begin
        nvalid++;
        chk_beat($sformatf("bp%0d", c), k % 4, 4, 16'hABCD, 2'd2);
        if (ready) begin
          nxfer++;
          k++;
        end
      end
      step();
    end
    ready = 1'b1;
    chk("bp.xfers", 64'(nxfer), 64'd8);
    chk("bp.valid_cycles", 64'(nvalid), 64'd16);
    chk("bp.idle", 64'(valid), 64'd0);

    // stop after the first beat: exactly one 3-beat packet
    do_reset();
    mm_write(2'd1, 16'd3);
    mm_write(2'd3, 16'h0A00);
    mm_write(2'd0, 16'h0001);
    chk_beat("stp0", 0, 3, 16'h0000, 2'd0);
    step();
    chk_beat("stp1", 1, 3, 16'h0000, 2'd0);
    mm_write(2'd0, 16'h0002);
    chk_beat("stp2", 2, 3, 16'h0000, 2'd0);
    step();
    chk("stp.idle", 64'(valid), 64'd0);
    step(); step();
    chk("stp.idle2", 64'(valid), 64'd0);
    mm_read(2'd0, rv); chk("stp.status", 64'(rv), 64'h4001);

    // zero length means one beat; config write while busy is ignored
    do_reset();
    mm_write(2'd1, 16'd0);
    ready = 1'b0;
    mm_write(2'd0, 16'h0001);
    chk_beat("one", 0, 1, 16'h0000, 2'd0);
    mm_write(2'd1, 16'd5);
    chk_beat("one.hold", 0, 1, 16'h0000, 2'd0);
    mm_read(2'd1, rv); chk("one.length", 64'(rv), 64'h0000);
    mm_read(2'd0, rv); chk("one.busy", 64'(rv), 64'h8000);
    ready = 1'b1;
    step();
    chk("one.idle", 64'(valid), 64'd0);
    mm_read(2'd0, rv); chk("one.status", 64'(rv), 64'h4001);
    mm_read(2'd0, rv); chk("one.done_clr", 64'(rv), 64'h0001);

    // packets-sent counter wraps after 256
    do_reset();
    ready = 1'b1;
    for (int p = 0; p < 255; p++) begin
      mm_write(2'd0, 16'h0001);
      step();
    end
    mm_read(2'd0, rv); chk("wrap.255", 64'(rv), 64'h40FF);
    mm_write(2'd0, 16'h0001);
    step();
    mm_read(2'd0, rv); chk("wrap.256", 64'(rv), 64'h4000);

    // reset mid-packet
    mm_write(2'd1, 16'd4);
    mm_write(2'd2, 16'h1234);
    mm_write(2'd3, 16'h0301);
    mm_write(2'd0, 16'h0001);
    step();
    chk_beat("mid", 1, 4, 16'h1234, 2'd1);
    reset = 1'b1;
    step();
    chk("mid.valid", 64'(valid), 64'd0);
    chk("mid.sop", 64'(startofpacket), 64'd0);
    chk("mid.data", 64'(data), 64'd0);
    reset = 1'b0;
    mm_read(2'd0, rv); chk("mid.ctrl", 64'(rv), 64'h0000);
    mm_read(2'd1, rv); chk("mid.length", 64'(rv), 64'h0001);
    mm_read(2'd2, rv); chk("mid.base", 64'(rv), 64'h0000);
    mm_read(2'd3, rv); chk("mid.shape", 64'(rv), 64'h0000);
    chk("mid.idle", 64'(valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
